riscv_dmem_ctrl: RTL and testbench

RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

---
 rtl/riscv_dmem_pkg.sv | 33 +++
 rtl/riscv_dmem_ctrl_load_align.sv | 32 +++
 rtl/riscv_dmem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_dmem_pkg -- access-size and FSM encodings for riscv_dmem_ctrl
// Rev 1.0
// ------------------------------------------------------------------
package riscv_dmem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_R = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_dmem_ctrl_load_align.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_load_align -- selects load lanes, right-aligns and extends them
// Rev 1.0
// ------------------------------------------------------------------
module riscv_load_align
  import riscv_dmem_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  assign shifted = word >> {off, 3'b000};

  always_comb begin
    data = word;
    case (size)
      SIZE_B:  data = is_unsigned ? {24'b0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  data = is_unsigned ? {16'b0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_dmem_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_dmem_ctrl -- wait-stated data memory; DMEM_MISALIGN_CHK_EN enables error replies
// Rev 1.0
// ------------------------------------------------------------------
module riscv_dmem_ctrl
  import riscv_dmem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ack_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam logic [3:0] WAIT_CNT    = 4'(WAIT);
  localparam state_e     FIRST_STATE = (WAIT == 0) ? S_RESP : S_WAIT;

  state_e                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [1:0]              off_q;
  logic [XLEN-1:0]         wdata_q;

  logic [XLEN-1:0]         mem [(1 << DEPTH_LOG2)];

  logic                    src_we;
  logic [1:0]              src_size;
  logic                    src_uns;
  logic [DEPTH_LOG2-1:0]   src_idx;
  logic [1:0]              src_off;
  logic [XLEN-1:0]         src_wdata;
  logic [1:0]              eff_size;
  logic [1:0]              eff_off;
  logic [3:0]              be;
  logic [XLEN-1:0]         wlanes;
  logic [XLEN-1:0]         rd_word;
  logic [XLEN-1:0]         load_data;
  logic                    bad;
  logic                    enter_resp;
  logic                    unused_addr;

  assign unused_addr = ^addr_i[AW-1:DEPTH_LOG2+2];

  // With no wait states the write happens on the accepting edge, so the
  // access attributes come straight from the inputs while still in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      src_we    = we_i;
      src_size  = size_i;
      src_uns   = unsigned_i;
      src_idx   = addr_i[DEPTH_LOG2+1:2];
      src_off   = addr_i[1:0];
      src_wdata = wdata_i;
    end else begin
      src_we    = we_q;
      src_size  = size_q;
      src_uns   = uns_q;
      src_idx   = idx_q;
      src_off   = off_q;
      src_wdata = wdata_q;
    end
  end

  always_comb begin
    eff_size = src_size;
    eff_off  = src_off;
    be       = 4'b1111;
    wlanes   = src_wdata;
    case (src_size)
      SIZE_B: begin
        be     = 4'b0001 << src_off;
        wlanes = {4{src_wdata[7:0]}};
      end
      SIZE_H: begin
        eff_off = {src_off[1], 1'b0};
        be      = 4'b0011 << eff_off;
        wlanes  = {2{src_wdata[15:0]}};
      end
      default: begin
        eff_size = SIZE_W;
        eff_off  = 2'b00;
      end
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  assign bad = misaligned(src_size, src_off);
`else
  assign bad = 1'b0;
`endif

  assign enter_resp = rst_i &&
                      (((state == S_IDLE) && req_i && (WAIT == 0)) ||
                       ((state == S_WAIT) && (cnt == 4'd1)));

  assign busy_o  = (state == S_WAIT) || (state == S_RESP);
  assign rd_word = mem[src_idx];

  riscv_load_align u_align (
    .word        (rd_word),
    .size        (eff_size),
    .off         (eff_off),
    .is_unsigned (src_uns),
    .data        (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      wdata_q <= '0;
    end else begin
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            idx_q   <= addr_i[DEPTH_LOG2+1:2];
            off_q   <= addr_i[1:0];
            wdata_q <= wdata_i;
            cnt     <= WAIT_CNT;
            state   <= FIRST_STATE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ack_o   <= 1'b1;
          err_o   <= bad;
          rdata_o <= (we_q || bad) ? '0 : load_data;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (enter_resp && src_we && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[src_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_ctrl.sv
`default_nettype none
// tb_riscv_dmem_ctrl -- table, directed and random checks of two controller
// instances (WAIT=1 and WAIT=3) against a byte-array reference model.
module tb_riscv_dmem_ctrl;

  localparam int DL        = 4;
  localparam int WA        = 1;
  localparam int WB        = 3;
  localparam int MEM_BYTES = 4 << DL;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_a, rst_b, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [31:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  riscv_dmem_ctrl #(.AW(32), .DEPTH_LOG2(DL), .WAIT(WA)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_a), .rdata_o(rdata_a), .err_o(err_a), .busy_o(busy_a)
  );

  riscv_dmem_ctrl #(.AW(32), .DEPTH_LOG2(DL), .WAIT(WB)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack_b), .rdata_o(rdata_b), .err_o(err_b), .busy_o(busy_b)
  );

  int checks = 0;
  int passed = 0;
  logic [7:0] bmem [MEM_BYTES];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, accesses aligned down to their size.
  function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic err);
    int n;
    int base;
    logic [31:0] v;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    err = CHK && ((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    rd  = 32'h0;
    if (err) return;
    base = (int'(a % MEM_BYTES) / n) * n;
    if (w) begin
      for (int i = 0; i < n; i++) bmem[base + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[base + i];
      if (!u && n == 1) v = {{24{v[7]}}, v[7:0]};
      if (!u && n == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.sz = sz; v.uns = u; v.addr = a; v.wd = d; v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  // One access on both instances; req stays high with junk stores while they
  // are busy, which must be ignored.
  task automatic run_access(input string tag, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_err);
    int n_a = 0, n_b = 0, lat_a = 0, lat_b = 0, stray = 0;
    logic [31:0] rd_a = 32'h0, rd_b = 32'h0;
    logic e_a = 1'b0, e_b = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b1; addr = $urandom; wdata = $urandom; size = 2'($urandom);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) req = 1'b0;
      @(posedge clk); #1;
      if (ack_a) begin n_a++; lat_a = c; rd_a = rdata_a; e_a = err_a; end
      else if (rdata_a != 32'h0) stray++;
      if (ack_b) begin n_b++; lat_b = c; rd_b = rdata_b; e_b = err_b; end
      else if (rdata_b != 32'h0) stray++;
    end
    chk({tag, " ack pulses A"}, n_a, 1);
    chk({tag, " ack pulses B"}, n_b, 1);
    chk({tag, " latency A"}, lat_a, WA + 1);
    chk({tag, " latency B"}, lat_b, WB + 1);
    chk({tag, " rdata A"}, rd_a, exp_rd);
    chk({tag, " rdata B"}, rd_b, exp_rd);
    chk({tag, " err A"}, {31'b0, e_a}, {31'b0, exp_err});
    chk({tag, " err B"}, {31'b0, e_b}, {31'b0, exp_err});
    chk({tag, " rdata idle zero"}, stray, 0);
  endtask

  initial begin
    logic [31:0] mr, r_addr, r_data;
    logic        me, r_we, r_uns;
    logic [1:0]  r_sz;
    int          n;

    rst_a = 1'b0; rst_b = 1'b0; req = 1'b0; we = 1'b0; uns = 1'b0;
    size = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset ack", {ack_a, ack_b}, 2'b00);
    chk("reset busy", {busy_a, busy_b}, 2'b00);
    chk("reset err", {err_a, err_b}, 2'b00);
    chk("reset rdata", rdata_a | rdata_b, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;

    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h13, 32'h80, 32'h0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h80000000, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h22, 32'hFFFF1234, 32'h0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0, 32'h00001234, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h1234F00D, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h21, 32'h11223344, 32'h0, CHK));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, CHK ? 32'hCAFEF00D : 32'h11223344, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h23, 32'h0, CHK ? 32'h0 : (32'hCAFEF00D ^ 32'hCAFEF00D ^ 32'h00001122), CHK));
    tbl.push_back(mk(0, 2'b11, 0, 32'h20, 32'h0, CHK ? 32'h0 : 32'h11223344, CHK));
    tbl.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF8000, 0));

    foreach (tbl[i]) begin
      run_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].uns,
                 tbl[i].addr, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err);
      model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, mr, me);
    end

    // Reset while both instances sit in WAIT on a store: the store is dropped.
    model(1'b1, 2'b10, 1'b0, 32'h30, 32'h5555AAAA, mr, me);
    run_access("rst pre", 1'b1, 2'b10, 1'b0, 32'h30, 32'h5555AAAA, 32'h0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'h0F0F0F0F;
    @(posedge clk); #2;
    req = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("abort busy", {busy_a, busy_b}, 2'b00);
    chk("abort ack", {ack_a, ack_b}, 2'b00);
    @(negedge clk); @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack_a || ack_b) n++;
    end
    chk("abort no ack", n, 0);
    model(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, mr, me);
    run_access("rst readback", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, mr, me);

    for (int i = 0; i < MEM_BYTES / 4; i++) begin
      r_data = $urandom;
      model(1'b1, 2'b10, 1'b0, 32'(4 * i), r_data, mr, me);
      run_access($sformatf("fill%0d", i), 1'b1, 2'b10, 1'b0, 32'(4 * i), r_data, mr, me);
    end

    for (int i = 0; i < 120; i++) begin
      r_we   = 1'($urandom);
      r_sz   = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom);
      r_addr = $urandom;
      r_data = $urandom;
      model(r_we, r_sz, r_uns, r_addr, r_data, mr, me);
      run_access($sformatf("rnd%0d", i), r_we, r_sz, r_uns, r_addr, r_data, mr, me);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
